// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit7..bit1 = a..g,
// bit0 = dp) and the display frame payload.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
    localparam int unsigned IDX_W      = 3;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Nibble -> segment code with dp off; entry 15 first, entry 0 last.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h19, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
    } frame_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment code (dp off).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output seg_t             seg_c_o
);

    // Table lookup
    assign seg_c_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_decode.sv
// Eight-digit time-multiplexed common-anode 7-segment driver.
// New frames are staged in a pending register and committed to the shadow
// register only at the 7->0 index wrap, so a frame never tears mid-scan.
// Optional macro SCAN_GHOST_BLANK_EN: blank c/en for the first GHOST_CYC
// divider counts of every digit slot to suppress ghosting.
module seg_scan_decode
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned GHOST_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data,
    input  logic [NUM_DIGITS-1:0] dp,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic                  load,
    output logic                  upd_done,
    output seg_t                  c,
    output logic [NUM_DIGITS-1:0] en
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

`ifdef SCAN_GHOST_BLANK_EN
    localparam bit GHOST_ON = 1'b1;
`else
    localparam bit GHOST_ON = 1'b0;
`endif

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_t                pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    frame_t                shad_q, shad_d;
    logic                  upd_q, upd_d;
    seg_t                  c_q, c_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    logic                  div_end_c;
    logic                  wrap_c;
    logic                  ghost_c;
    logic [NIB_W-1:0]      nib_c;
    seg_t                  seg_c;

    // Current digit's nibble decoded through the shared table
    hex_to_seg u_hex_to_seg (
        .nib_i   (nib_c),
        .seg_c_o (seg_c)
    );

    // Next-state for divider, index, frame staging and registered outputs
    always_comb begin
        div_end_c  = (div_q == DIV_W'(CLK_DIV - 1));
        wrap_c     = div_end_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
        ghost_c    = GHOST_ON && (div_q < DIV_W'(GHOST_CYC));
        nib_c      = shad_q.data[{idx_q, 2'b00} +: NIB_W];

        div_d      = div_end_c ? '0 : div_q + DIV_W'(1);
        idx_d      = div_end_c ? idx_q + IDX_W'(1) : idx_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q & ~wrap_c;
        shad_d     = shad_q;
        upd_d      = 1'b0;
        en_d       = ~(NUM_DIGITS'(1) << idx_q);
        c_d        = {seg_c[7:1], seg_c[0] & ~shad_q.dp[idx_q]};

        // A load on the wrap cycle stays pending; the older pending frame commits
        if (wrap_c && pend_vld_q) begin
            shad_d = pend_q;
            upd_d  = 1'b1;
        end
        if (load) begin
            pend_d     = '{data: data, dp: dp, blank: blank};
            pend_vld_d = 1'b1;
        end

        if (shad_q.blank[idx_q]) begin
            c_d = SEG_OFF;
        end
        if (ghost_c) begin
            c_d  = SEG_OFF;
            en_d = '1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            shad_q     <= '0;
            upd_q      <= 1'b0;
            c_q        <= SEG_OFF;
            en_q       <= '1;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            shad_q     <= shad_d;
            upd_q      <= upd_d;
            c_q        <= c_d;
            en_q       <= en_d;
        end
    end

    assign upd_done = upd_q;
    assign c        = c_q;
    assign en       = en_q;

endmodule

// File: tb/tb_seg_scan_decode.sv
// Bench for seg_scan_decode with CLK_DIV = 4, GHOST_CYC = 1.
// Expected frames are queued on load and become the reference display when
// upd_done is seen; every cycle of each checked frame compares en/c/upd_done.
module tb_seg_scan_decode;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned GHOST_CYC = 1;
    localparam int unsigned FRAME_CYC = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        upd_done;
    logic [7:0]  c;
    logic [7:0]  en;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [63:0] exp_c;   // digit k segment code at [8k +: 8]
    } vec_t;

    vec_t        vecs [5];
    vec_t        none_v;
    vec_t        h1, h2, h3, hr;
    logic [63:0] sb_q [$];
    logic [63:0] cur;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] ZEROS = 64'h0303030303030303;

    always #5 clk = ~clk;

    seg_scan_decode #(
        .CLK_DIV   (CLK_DIV),
        .GHOST_CYC (GHOST_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .dp       (dp),
        .blank    (blank),
        .load     (load),
        .upd_done (upd_done),
        .c        (c),
        .en       (en)
    );

    task automatic check(input string name, input int cyc, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Drive a one-cycle load; a second load before the wrap replaces the queued frame
    task automatic drive_load(input vec_t v);
        data  = v.data;
        dp    = v.dp;
        blank = v.blank;
        load  = 1'b1;
        if (sb_q.size() > 0) sb_q[sb_q.size()-1] = v.exp_c;
        else                 sb_q.push_back(v.exp_c);
    endtask

    // Check one full frame starting at the negedge after digit 0's first edge
    task automatic run_frame(input int l1, input vec_t a, input int l2, input vec_t b, input bit exp_upd);
        int          k;
        int          pos;
        logic [7:0]  exp_en;
        logic [7:0]  exp_cv;
        for (int i = 1; i <= int'(FRAME_CYC); i++) begin
            @(negedge clk);
            load   = 1'b0;
            k      = (i - 1) / int'(CLK_DIV);
            pos    = (i - 1) % int'(CLK_DIV);
            exp_en = ~(8'b1 << k);
            exp_cv = cur[8*k +: 8];
`ifdef SCAN_GHOST_BLANK_EN
            if (pos < int'(GHOST_CYC)) begin
                exp_en = 8'hFF;
                exp_cv = 8'hFF;
            end
`endif
            check("en", i, en, exp_en);
            check("c", i, c, exp_cv);
            check("upd_done", i, {7'b0, upd_done}, {7'b0, (i == int'(FRAME_CYC)) ? exp_upd : 1'b0});
            if (i == int'(FRAME_CYC) && upd_done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop cyc=%0d got=upd_done exp=no_pending", i);
                end else begin
                    cur = sb_q.pop_front();
                end
            end
            if (i == l1) drive_load(a);
            if (i == l2) drive_load(b);
        end
    endtask

    initial begin
        none_v  = '{32'h0, 8'h00, 8'h00, 64'h0};
        vecs[0] = '{32'hFEDCBA98, 8'h00, 8'h00, 64'h71_61_85_63_C1_11_19_01};
        vecs[1] = '{32'h00000001, 8'h01, 8'h00, 64'h03_03_03_03_03_03_03_9E};
        vecs[2] = '{32'h76543210, 8'h00, 8'h80, 64'hFF_41_49_99_0D_25_9F_03};
        vecs[3] = '{32'h89ABCDEF, 8'hF0, 8'h0F, 64'h00_18_10_C0_FF_FF_FF_FF};
        vecs[4] = '{32'h5A5A5A5A, 8'h00, 8'h00, 64'h49_11_49_11_49_11_49_11};
        h1      = '{32'h00000001, 8'h00, 8'h00, 64'h03_03_03_03_03_03_03_9F};
        h2      = '{32'h00000002, 8'h00, 8'h00, 64'h03_03_03_03_03_03_03_25};
        h3      = '{32'h00000003, 8'h00, 8'h00, 64'h03_03_03_03_03_03_03_0D};
        hr      = '{32'h88888888, 8'hFF, 8'h00, 64'h00_00_00_00_00_00_00_00};

        rst_n = 1'b0;
        load  = 1'b0;
        data  = 32'h0;
        dp    = 8'h0;
        blank = 8'h0;
        repeat (3) @(negedge clk);
        check("rst_c", 0, c, 8'hFF);
        check("rst_en", 0, en, 8'hFF);
        check("rst_upd", 0, {7'b0, upd_done}, 8'h00);
        rst_n = 1'b1;
        cur   = ZEROS;

        // First frame after reset: all zeros, no update
        run_frame(-1, none_v, -1, none_v, 1'b0);

        // Table vectors: each loaded mid-frame, visible from the following frame
        for (int v = 0; v < 5; v++) begin
            run_frame(5, vecs[v], -1, none_v, 1'b1);
        end
        run_frame(-1, none_v, -1, none_v, 1'b0);

        // Two loads before one wrap: last wins, one upd_done
        run_frame(3, h1, 10, h2, 1'b1);
        // Load on the wrap cycle itself: held until the following wrap
        run_frame(FRAME_CYC - 1, h3, -1, none_v, 1'b0);
        run_frame(-1, none_v, -1, none_v, 1'b1);
        run_frame(-1, none_v, -1, none_v, 1'b0);

        // Mid-slot reset with a pending update
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (i == 2) drive_load(hr);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_c", 0, c, 8'hFF);
        check("arst_en", 0, en, 8'hFF);
        check("arst_upd", 0, {7'b0, upd_done}, 8'h00);
        sb_q.delete();
        cur = ZEROS;
        repeat (2) @(negedge clk);
        check("hold_c", 0, c, 8'hFF);
        check("hold_en", 0, en, 8'hFF);
        rst_n = 1'b1;
        run_frame(-1, none_v, -1, none_v, 1'b0);
        run_frame(-1, none_v, -1, none_v, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
